// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: request-driven S/R pulse generator with shadow state, q check and pulse counters
module sr_cmd_gen #(
   parameter int PULSE_W = 1,
   parameter int GAP = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_d,
   input  logic       in_refresh,
   input  logic       clr_err,
   input  logic       fb_q,
   output logic       s,
   output logic       r,
   output logic       busy,
   output logic       shadow_q,
   output logic       mismatch,
   output logic [7:0] cnt_set,
   output logic [7:0] cnt_rst
);
   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_CHECK, ST_GAP} state_t;
   localparam logic [3:0] PW4 = 4'(PULSE_W);
   localparam logic [3:0] GAP4 = 4'(GAP);
   state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic d_lat, d_n, go;
   assign in_ready = (state == ST_IDLE) && rstn;
   assign go = in_valid && in_ready && (in_d != shadow_q || in_refresh);
   assign d_n = go ? in_d : d_lat;
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      case (state)
         ST_IDLE: begin
            state_n = go ? ST_PULSE : ST_IDLE;
            cnt_n = go ? PW4 : cnt;
         end
         ST_PULSE: begin
            state_n = (cnt == 4'd1) ? ST_CHECK : ST_PULSE;
            cnt_n = cnt - 4'd1;
         end
         ST_CHECK: begin
            state_n = (GAP4 == 4'd0) ? ST_IDLE : ST_GAP;
            cnt_n = GAP4;
         end
         ST_GAP: begin
            state_n = (cnt == 4'd1) ? ST_IDLE : ST_GAP;
            cnt_n = cnt - 4'd1;
         end
         default: state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= ST_IDLE;
         cnt <= 4'd0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   end
   // outputs are registered from the next state so s/r align with PULSE cycles
   always_ff @(posedge clk) begin
      if (!rstn) begin
         d_lat <= 1'b0;
         shadow_q <= 1'b0;
         s <= 1'b0;
         r <= 1'b0;
         busy <= 1'b0;
         mismatch <= 1'b0;
         cnt_set <= 8'd0;
         cnt_rst <= 8'd0;
      end else begin
         d_lat <= d_n;
         if (go) shadow_q <= in_d;
         s <= (state_n == ST_PULSE) && d_n;
         r <= (state_n == ST_PULSE) && !d_n;
         busy <= state_n != ST_IDLE;
         if (go && in_d && cnt_set != 8'hff) cnt_set <= cnt_set + 8'd1;
         if (go && !in_d && cnt_rst != 8'hff) cnt_rst <= cnt_rst + 8'd1;
         if (state == ST_CHECK && fb_q != shadow_q) mismatch <= 1'b1;
         else if (clr_err) mismatch <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: schedule-based reference model for two sr_cmd_gen configurations plus directed literal checks
module tb_sr_cmd_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic [1:0] rstn = 2'b00, in_valid = 2'b00, in_d = 2'b00, in_refresh = 2'b00, clr_err = 2'b00, stuck = 2'b00;
   wire [1:0] in_ready, s, r, busy, shadow_q, mismatch, fb_q;
   wire [7:0] cnt_set [2];
   wire [7:0] cnt_rst [2];
   int errors = 0, checks = 0;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int PW = (g == 0) ? 2 : 4;
      localparam int GP = (g == 0) ? 1 : 0;
      logic ff_q = 1'b0;
      int cyc = 0, t = 0;
      logic act = 1'b0, m_d = 1'b0, m_sh = 1'b0, m_mis = 1'b0;
      logic [7:0] m_set = 8'd0, m_rst = 8'd0;
      logic e_busy, e_s, e_r, e_ready;
      sr_cmd_gen #(.PULSE_W(PW), .GAP(GP)) dut (
         .clk(clk), .rstn(rstn[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_d(in_d[g]), .in_refresh(in_refresh[g]), .clr_err(clr_err[g]), .fb_q(fb_q[g]),
         .s(s[g]), .r(r[g]), .busy(busy[g]), .shadow_q(shadow_q[g]), .mismatch(mismatch[g]),
         .cnt_set(cnt_set[g]), .cnt_rst(cnt_rst[g]));
      // ideal SR flip-flop, optionally disconnected to force a stuck-at-0 readback
      assign fb_q[g] = stuck[g] ? 1'b0 : ff_q;
      always @(posedge clk) begin
         if (!rstn[g]) ff_q <= 1'b0;
         else if (s[g]) ff_q <= 1'b1;
         else if (r[g]) ff_q <= 1'b0;
      end
      // last effective request accepted at cycle t: pulse t+1..t+PW, check t+PW+1, busy to t+PW+1+GP
      always_comb begin
         e_busy = act && cyc >= t + 1 && cyc <= t + PW + 1 + GP;
         e_s = act && cyc >= t + 1 && cyc <= t + PW && m_d;
         e_r = act && cyc >= t + 1 && cyc <= t + PW && !m_d;
         e_ready = rstn[g] && !e_busy;
      end
      always @(posedge clk) begin
         cyc <= cyc + 1;
         if (!rstn[g]) begin
            act <= 1'b0;
            m_sh <= 1'b0;
            m_mis <= 1'b0;
            m_set <= 8'd0;
            m_rst <= 8'd0;
         end else begin
            if (in_valid[g] && e_ready && (in_d[g] != m_sh || in_refresh[g])) begin
               act <= 1'b1;
               t <= cyc;
               m_d <= in_d[g];
               m_sh <= in_d[g];
               if (in_d[g]) m_set <= (m_set == 8'd255) ? 8'd255 : m_set + 8'd1;
               else m_rst <= (m_rst == 8'd255) ? 8'd255 : m_rst + 8'd1;
            end
            if (act && cyc == t + PW + 1 && fb_q[g] != m_sh) m_mis <= 1'b1;
            else if (clr_err[g]) m_mis <= 1'b0;
         end
      end
      always @(negedge clk) begin
         checks++;
         if ({in_ready[g], s[g], r[g], busy[g], shadow_q[g], mismatch[g], cnt_set[g], cnt_rst[g]} !==
             {e_ready, e_s, e_r, e_busy, m_sh, m_mis, m_set, m_rst}) begin
            errors++;
            $display("FAIL model u%0d cyc=%0d got rdy,s,r,busy,sh,mis=%b%b%b%b%b%b set=%0d rst=%0d exp=%b%b%b%b%b%b set=%0d rst=%0d",
                     g, cyc, in_ready[g], s[g], r[g], busy[g], shadow_q[g], mismatch[g], cnt_set[g], cnt_rst[g],
                     e_ready, e_s, e_r, e_busy, m_sh, m_mis, m_set, m_rst);
         end
         checks++;
         assert (!(s[g] && r[g])) else begin
            errors++;
            $display("FAIL excl u%0d cyc=%0d s and r both high", g, cyc);
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic send(int i, logic d, logic rf);
      int n = 0;
      in_valid[i] = 1'b1;
      in_d[i] = d;
      in_refresh[i] = rf;
      while (!in_ready[i] && n < 50) begin
         tick(1);
         n++;
      end
      chk("ready_wait", 32'(in_ready[i]), 1);
      tick(1);
      in_valid[i] = 1'b0;
      in_refresh[i] = 1'b0;
   endtask

   initial begin
      int lo, hi;
      tick(2);
      chk("ready_in_rst", 32'(in_ready[0]), 0);
      chk("cnt_set_rst", 32'(cnt_set[0]), 0);
      chk("shadow_rst", 32'(shadow_q[0]), 0);
      rstn = 2'b11;
      #1;
      chk("ready_after_rst", 32'(in_ready[0]), 1);
      // first S pulse with ideal feedback
      send(0, 1'b1, 1'b0);
      chk("s_first", 32'(s[0]), 1);
      chk("r_first", 32'(r[0]), 0);
      chk("shadow_first", 32'(shadow_q[0]), 1);
      chk("cnt_set_first", 32'(cnt_set[0]), 1);
      lo = 0;
      hi = 0;
      while (!in_ready[0] && lo < 20) begin
         if (s[0]) hi++;
         lo++;
         tick(1);
      end
      chk("ready_low_cycles", 32'(lo), 4);
      chk("s_high_cycles", 32'(hi), 2);
      chk("mis_first", 32'(mismatch[0]), 0);
      chk("cnt_rst_first", 32'(cnt_rst[0]), 0);
      // equal value without refresh is a no-op
      send(0, 1'b1, 1'b0);
      chk("noop_busy", 32'(busy[0]), 0);
      chk("noop_ready", 32'(in_ready[0]), 1);
      chk("noop_s", 32'(s[0]), 0);
      chk("noop_cnt", 32'(cnt_set[0]), 1);
      send(0, 1'b1, 1'b1);
      chk("refresh_s", 32'(s[0]), 1);
      chk("refresh_cnt", 32'(cnt_set[0]), 2);
      // stuck feedback mismatch, clear, and set-over-clear
      send(0, 1'b0, 1'b0);
      stuck[0] = 1'b1;
      send(0, 1'b1, 1'b0);
      tick(3);
      chk("mis_set", 32'(mismatch[0]), 1);
      tick(1);
      chk("mis_sticky", 32'(mismatch[0]), 1);
      clr_err[0] = 1'b1;
      tick(1);
      clr_err[0] = 1'b0;
      chk("mis_clr", 32'(mismatch[0]), 0);
      send(0, 1'b1, 1'b1);
      tick(2);
      clr_err[0] = 1'b1;
      tick(1);
      clr_err[0] = 1'b0;
      chk("mis_set_wins", 32'(mismatch[0]), 1);
      stuck[0] = 1'b0;
      clr_err[0] = 1'b1;
      tick(1);
      clr_err[0] = 1'b0;
      chk("mis_clr2", 32'(mismatch[0]), 0);
      chk("cnt_set_mid", 32'(cnt_set[0]), 4);
      chk("cnt_rst_mid", 32'(cnt_rst[0]), 1);
      // enough alternating requests to saturate both counters
      for (int k = 0; k < 520; k++) send(0, k[0], 1'b0);
      tick(6);
      chk("cnt_set_sat", 32'(cnt_set[0]), 255);
      chk("cnt_rst_sat", 32'(cnt_rst[0]), 255);
      chk("mis_after_sat", 32'(mismatch[0]), 0);
      // reset in the middle of a 4-cycle pulse
      send(1, 1'b1, 1'b0);
      chk("u1_s_start", 32'(s[1]), 1);
      tick(1);
      rstn[1] = 1'b0;
      tick(1);
      chk("u1_s_rst", 32'(s[1]), 0);
      chk("u1_shadow_rst", 32'(shadow_q[1]), 0);
      chk("u1_cnt_rst", 32'(cnt_set[1]), 0);
      chk("u1_busy_rst", 32'(busy[1]), 0);
      chk("u1_ready_in_rst", 32'(in_ready[1]), 0);
      rstn[1] = 1'b1;
      #1;
      chk("u1_ready_after", 32'(in_ready[1]), 1);
      tick(1);
      chk("u1_no_resume", 32'(s[1]), 0);
      chk("u1_idle", 32'(busy[1]), 0);
      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
